// File: rtl/output_argmax_pkg.sv
// Shared constants, state encoding and width helper for the output argmax block.
package output_argmax_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int INDEX_WIDTH = 4;

  // Index of the final class compared in a search.
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_CLASSES - 1);

  // Width of a layer-2 leaky output: a product of activation and weight,
  // accumulated and passed through the leaky stage, plus one guard bit.
  function automatic int calc_data_size(input int leaky_size, input int weight_size);
    return 2 * (leaky_size + weight_size) + 1;
  endfunction

  localparam int DEFAULT_DATA_SIZE = calc_data_size(32, 8);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/output_argmax_compare.sv
// Single signed comparator plus select mux: keeps the incumbent unless the
// candidate is strictly greater, so ties stay with the lower index.
module argmax_compare
  import output_argmax_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
  input  logic [DATA_SIZE-1:0]   cand_val,
  input  logic [INDEX_WIDTH-1:0] cand_idx,
  input  logic [DATA_SIZE-1:0]   best_val,
  input  logic [INDEX_WIDTH-1:0] best_idx,
  output logic [DATA_SIZE-1:0]   sel_val,
  output logic [INDEX_WIDTH-1:0] sel_idx
);

  logic take;

  // Scores are two's-complement, so the compare must be signed.
  always_comb begin
    take    = $signed(cand_val) > $signed(best_val);
    sel_val = take ? cand_val : best_val;
    sel_idx = take ? cand_idx : best_idx;
  end

endmodule

// File: rtl/output_argmax.sv
// Sequential argmax over the ten layer-2 class scores. A load snapshots the
// scores, one comparator walks them over nine cycles, and a final cycle
// publishes the winner and raises done.
module output_argmax
  import output_argmax_pkg::*;
#(
  parameter int LEAKY_LAYER_SIZE = 32,
  parameter int WEIGHT_SIZE      = 8,
  parameter int DATA_SIZE        = calc_data_size(LEAKY_LAYER_SIZE, WEIGHT_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DATA_SIZE-1:0]   layer_2_output_leaky_1,
  input  logic [DATA_SIZE-1:0]   layer_2_output_leaky_2,
  input  logic [DATA_SIZE-1:0]   layer_2_output_leaky_3,
  input  logic [DATA_SIZE-1:0]   layer_2_output_leaky_4,
  input  logic [DATA_SIZE-1:0]   layer_2_output_leaky_5,
  input  logic [DATA_SIZE-1:0]   layer_2_output_leaky_6,
  input  logic [DATA_SIZE-1:0]   layer_2_output_leaky_7,
  input  logic [DATA_SIZE-1:0]   layer_2_output_leaky_8,
  input  logic [DATA_SIZE-1:0]   layer_2_output_leaky_9,
  input  logic [DATA_SIZE-1:0]   layer_2_output_leaky_10,
  output logic [INDEX_WIDTH-1:0] class_index,
  output logic [DATA_SIZE-1:0]   max_value,
  output logic                   done
);

  state_t                 state;
  state_t                 next_state;
  logic [DATA_SIZE-1:0]   scores [NUM_CLASSES];
  logic [DATA_SIZE-1:0]   bank   [NUM_CLASSES];
  logic [DATA_SIZE-1:0]   best_val;
  logic [INDEX_WIDTH-1:0] best_idx;
  logic [INDEX_WIDTH-1:0] counter;
  logic                   search_done;
  logic [DATA_SIZE-1:0]   sel_val;
  logic [INDEX_WIDTH-1:0] sel_idx;
  logic                   accept;

  assign scores[0] = layer_2_output_leaky_1;
  assign scores[1] = layer_2_output_leaky_2;
  assign scores[2] = layer_2_output_leaky_3;
  assign scores[3] = layer_2_output_leaky_4;
  assign scores[4] = layer_2_output_leaky_5;
  assign scores[5] = layer_2_output_leaky_6;
  assign scores[6] = layer_2_output_leaky_7;
  assign scores[7] = layer_2_output_leaky_8;
  assign scores[8] = layer_2_output_leaky_9;
  assign scores[9] = layer_2_output_leaky_10;

  // A load is honoured only when not already searching.
  assign accept = load && (state != ST_COMPARE);

  argmax_compare #(
    .DATA_SIZE(DATA_SIZE)
  ) u_compare (
    .cand_val(bank[counter]),
    .cand_idx(counter),
    .best_val(best_val),
    .best_idx(best_idx),
    .sel_val (sel_val),
    .sel_idx (sel_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic: start on an accepted load, finish after the last compare.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven and avoids a latch.
    next_state = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (load)        next_state = ST_COMPARE;
      ST_COMPARE:       if (search_done) next_state = ST_DONE;
      default:                           next_state = ST_IDLE;
    endcase
  end

  // Datapath: snapshot on load, fold one score per cycle, publish on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the score bank is cleared on reset because a stale snapshot must
      // never be observable; this is a small register bank, not a RAM.
      for (int i = 0; i < NUM_CLASSES; i++) bank[i] <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      counter     <= '0;
      search_done <= 1'b0;
      class_index <= '0;
      max_value   <= '0;
      done        <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < NUM_CLASSES; i++) bank[i] <= scores[i];
      best_val    <= scores[0];
      best_idx    <= '0;
      counter     <= INDEX_WIDTH'(1);
      search_done <= 1'b0;
      done        <= 1'b0;
    end else if (state == ST_COMPARE) begin
      if (search_done) begin
        class_index <= best_idx;
        max_value   <= best_val;
        done        <= 1'b1;
      end else begin
        best_val <= sel_val;
        best_idx <= sel_idx;
        // Counter parks on the last index instead of wrapping.
        if (counter == LAST_INDEX) search_done <= 1'b1;
        else                       counter     <= counter + INDEX_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/output_argmax.md
OUTPUT_ARGMAX -- requirements
Module: output_argmax

Interface
REQ-001 Parameter LEAKY_LAYER_SIZE, default 32: layer-1 activation width feeding layer 2.
REQ-002 Parameter WEIGHT_SIZE, default 8: layer-2 weight width.
REQ-003 Parameter DATA_SIZE, default 2*(LEAKY_LAYER_SIZE+WEIGHT_SIZE)+1 = 81: width of each layer-2 leaky output.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 load  input  1  start pulse; driven by layer-2 done_complete.
REQ-007 layer_2_output_leaky_1 .. layer_2_output_leaky_10  input  DATA_SIZE each  class scores, two's-complement signed; _k maps to digit k-1.
REQ-008 class_index  output  4  winning digit, 0..9.
REQ-009 max_value  output  DATA_SIZE  score of the winning class.
REQ-010 done  output  1  result valid.

Function
REQ-011 States SHALL be IDLE, COMPARE, DONE; encodings defined in the shared package.
REQ-012 In IDLE or DONE, load=1 at a rising edge SHALL capture all ten inputs into an internal bank, set best_val=input_1, best_idx=0, counter=1, clear done, and enter COMPARE.
REQ-013 In COMPARE, each cycle SHALL compare bank[counter] with best_val as signed DATA_SIZE values; if strictly greater, best_val/best_idx take bank[counter]/counter; counter increments.
REQ-014 After the compare with counter=9 the FSM SHALL enter DONE: exactly 10 cycles from the load-sampling edge to done high.
REQ-015 On entering DONE, class_index and max_value SHALL update from best_idx/best_val in the same edge that sets done.
REQ-016 done SHALL stay high in DONE until the next accepted load or reset.
REQ-017 Ties SHALL resolve to the lowest index (strict greater-than only).
REQ-018 load during COMPARE SHALL be ignored; the inputs are not resampled.
REQ-019 Inputs SHALL be sampled only at the load edge; later input changes do not affect the result.
REQ-020 class_index and max_value SHALL hold their last values between done pulses, including during a new COMPARE.
REQ-021 The counter SHALL never exceed 9; no wrap-around state is reachable.

Reset
REQ-022 reset=1 SHALL force state IDLE, counter=0, best_idx=0, best_val=0, bank=0, class_index=0, max_value=0, done=0, asynchronously.
REQ-023 reset asserted mid-COMPARE SHALL abort the search; no done is produced for the aborted load.
REQ-024 First load after reset deassertion SHALL be honoured on the first rising edge where reset=0.

Structure
REQ-025 Shared package/include: NUM_CLASSES=10, INDEX_WIDTH=4, DATA_SIZE derivation, state encodings.
REQ-026 One sub-module, argmax_compare: combinational signed greater-than of two DATA_SIZE values plus select mux for value/index.
REQ-027 Target size 120-300 RTL lines; one comparator, no parallel compare tree.

Verification
REQ-028 Scores 0..9 on inputs _1.._10 (value = index), load pulse -> done at +10 cycles, class_index=9, max_value=9.
REQ-029 All scores -5 except _4 = -1 -> class_index=3, max_value=-1 (signed compare, not unsigned).
REQ-030 _3 and _7 both 100, others 0 -> class_index=2 (tie to lowest).
REQ-031 load, then change all inputs and pulse load again at +4 cycles -> result reflects first vector only, done at +10 from first load.
REQ-032 load, reset asserted at +5 cycles for 1 cycle -> all outputs 0, done stays 0, IDLE; a fresh load then completes normally.
REQ-033 _1 = most positive 81-bit value, _2 = most negative, rest 0 -> class_index=0; back-to-back load in DONE restarts with done dropping for 10 cycles.
